div_sequencer: RTL

Controller that shares the MIPS core's iterative restoring-divider datapath between two requesters. It arbitrates incoming div/divu requests, converts operands to magnitudes, and sequences the datapath one iteration per cycle. It then applies MIPS sign rules to the result and writes the HI/LO register pair. It sits between the EX stage (port 0) and a secondary requester (port 1) on one side, and the shift/add-sub datapath on the other.

---
 rtl/div_seq_pkg.sv | 22 ++
 rtl/div_sequencer_if.sv | 30 +++
 rtl/div_sequencer_arb.sv | 36 +++
 rtl/div_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the divider sequencer.
//   state_e    : controller states
//   OP_*       : datapath command encodings driven on dp_op
//   DEFAULT_W  : default operand width
package div_seq_pkg;

  localparam int DEFAULT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

endpackage

// File: rtl/div_sequencer_if.sv
// Request bus shared by the two divide requesters.
//   req_valid[i]   : port i presents a request
//   req_signed[i]  : 1 = div, 0 = divu
//   req_dividend   : packed operands, port i at [i*W +: W]
//   req_divisor    : packed operands, port i at [i*W +: W]
//   req_ready[i]   : grant; accept when valid and ready are both high
// master = requester side, slave = sequencer side.
interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int W = DEFAULT_W
) ();

  logic [1:0]     req_valid;
  logic [1:0]     req_signed;
  logic [2*W-1:0] req_dividend;
  logic [2*W-1:0] req_divisor;
  logic [1:0]     req_ready;

  modport master (
    output req_valid, req_signed, req_dividend, req_divisor,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_signed, req_dividend, req_divisor,
    output req_ready
  );

endinterface

// File: rtl/div_sequencer_arb.sv
// Two-port round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requesting ports
//   enable     : grants are only issued while high
//   advance    : a grant was taken this cycle; move the pointer
//   grant[1:0] : one-hot (or zero) grant, combinational
// The last-grant pointer resets to 1 so port 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_last;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = r_last ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last <= 1'b1;
    else if (advance) r_last <= grant[1];
  end

endmodule

// File: rtl/div_sequencer.sv
// Sequencer sharing an iterative restoring-divider datapath between two
// requesters, applying MIPS div/divu sign rules and writing HI/LO.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req                 : request bus (slave side), two ports
//   flush               : aborts the operation in flight (not in DONE)
//   dp_op               : datapath command (HOLD/LOAD/SUB/SHIFT), combinational
//   dp_dividend/divisor : operand magnitudes, used while dp_op = LOAD
//   dp_rsubd            : datapath R - D (sign bit chooses SUB vs SHIFT)
//   dp_quo, dp_rem      : datapath quotient / remainder magnitudes
//   done, done_id       : one-cycle completion pulse and owning port
//   div_by_zero         : qualifies done
//   hi, lo              : remainder / quotient registers
//   busy                : sequencer not idle
module div_sequencer
  import div_seq_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  div_seq_if.slave       req,
  input  logic           flush,
  output logic [1:0]     dp_op,
  output logic [W-1:0]   dp_dividend,
  output logic [W-1:0]   dp_divisor,
  input  logic [2*W-1:0] dp_rsubd,
  input  logic [W-1:0]   dp_quo,
  input  logic [W-1:0]   dp_rem,
  output logic           done,
  output logic           done_id,
  output logic           div_by_zero,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic           busy
);

  localparam int CW = $clog2(W + 1);

  state_e          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_id, r_sign_q, r_sign_r;
  logic [W-1:0]    r_dvd_mag, r_dvs_mag, r_hi, r_lo;
  logic            r_done, r_dbz, r_busy;

  logic [1:0]      w_grant;
  logic            w_enable, w_accept, w_sel, w_sgn;
  logic [W-1:0]    w_a, w_b, w_a_mag, w_b_mag;
  logic            w_a_neg, w_b_neg, w_b_zero;
  logic            w_unused;

  // Only the sign of R - D matters to the sequencer.
  assign w_unused = ^dp_rsubd[2*W-2:0];

  // Arbitration happens only in IDLE and never while flushing.
  assign w_enable      = (r_state == S_IDLE) && !flush;
  assign req.req_ready = w_grant;
  assign w_accept      = |w_grant;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req.req_valid),
    .enable (w_enable),
    .advance(w_accept),
    .grant  (w_grant)
  );

  // Operands of the granted port.
  assign w_sel    = w_grant[1];
  assign w_a      = w_sel ? req.req_dividend[2*W-1:W] : req.req_dividend[W-1:0];
  assign w_b      = w_sel ? req.req_divisor[2*W-1:W]  : req.req_divisor[W-1:0];
  assign w_sgn    = w_sel ? req.req_signed[1] : req.req_signed[0];
  assign w_a_neg  = w_sgn && w_a[W-1];
  assign w_b_neg  = w_sgn && w_b[W-1];
  assign w_a_mag  = w_a_neg ? -w_a : w_a;
  assign w_b_mag  = w_b_neg ? -w_b : w_b;
  assign w_b_zero = (w_b == '0);

  // Next state and datapath command. flush wins over every transition except
  // DONE, whose HI/LO write has already happened.
  always_comb begin
    w_next = r_state;
    dp_op  = OP_HOLD;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_b_zero ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (flush) w_next = S_IDLE;
        else begin
          dp_op  = OP_LOAD;
          w_next = S_ITER;
        end
      end
      S_ITER: begin
        if (flush) w_next = S_IDLE;
        else begin
          // Negative trial remainder: restore (just shift, q bit 0).
          dp_op = dp_rsubd[2*W-1] ? OP_SHIFT : OP_SUB;
          if (r_cnt == CW'(W - 1)) w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Iteration counter: cleared outside ITER, so it counts 0..W and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (r_state == S_ITER)  r_cnt <= r_cnt + CW'(1);
    else                         r_cnt <= '0;
  end

  // Operation context captured on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id      <= 1'b0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_dvd_mag <= '0;
      r_dvs_mag <= '0;
    end else if (w_accept) begin
      r_id      <= w_sel;
      r_sign_q  <= w_a_neg ^ w_b_neg;
      r_sign_r  <= w_a_neg;
      r_dvd_mag <= w_a_mag;
      r_dvs_mag <= w_b_mag;
    end
  end

  // HI/LO: written directly on a divide-by-zero accept, otherwise at the end
  // of an unflushed FIX cycle with the sign rules applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_accept && w_b_zero) begin
      r_hi <= w_a;
      r_lo <= '1;
    end else if (r_state == S_FIX && !flush) begin
      r_hi <= r_sign_r ? -dp_rem : dp_rem;
      r_lo <= r_sign_q ? -dp_quo : dp_quo;
    end
  end

  // Registered status outputs, derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= (w_next == S_DONE);
      r_dbz  <= (w_next == S_DONE) && (r_state == S_IDLE);
      r_busy <= (w_next != S_IDLE);
    end
  end

  assign dp_dividend = r_dvd_mag;
  assign dp_divisor  = r_dvs_mag;
  assign done        = r_done;
  assign done_id     = r_id;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = r_busy;

endmodule
